// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default sizes for the data-memory responder
package dmem_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DEPTH     = 256;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter
    import dmem_pkg::*;
#(
    parameter int N     = DEF_NUM_CORES,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int c;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        c           = 0;
        // Walk N slots beginning one past the previous winner; first hit wins.
        for (int i = 1; i <= N; i++) begin
            c = (int'(last_grant) + i) % N;
            if (!grant_valid && req[c]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(c);
                grant[c]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - captures per-core memory requests and serves them round-robin
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        RESET_N,
    input  logic [NUM_CORES-1:0]        req_rd,
    input  logic [NUM_CORES-1:0]        req_wr,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES*DATA_W-1:0] rdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [NUM_CORES-1:0]        overrun,
    output logic                        busy
);

    localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int MEM_AW = $clog2(DEPTH);

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   prev_q, pending_q, req_any, rise, set_pend;
    op_t                    op_q    [NUM_CORES];
    logic [MEM_AW-1:0]      addr_q  [NUM_CORES];
    logic [DATA_W-1:0]      wdata_q [NUM_CORES];
    logic [DATA_W-1:0]      rdata_q [NUM_CORES];
    logic [IDX_W-1:0]       grant_q, last_grant_q, arb_idx;
    logic [NUM_CORES-1:0]   grant_oh_q, arb_oh;
    logic                   arb_valid;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DATA_W-1:0]      rd_q;
    logic                   unused_addr;

    assign req_any     = req_rd | req_wr;
    assign rise        = req_any & ~prev_q;
    assign set_pend    = rise & ~pending_q;
    assign ack         = (state_q == RESPOND) ? grant_oh_q : '0;
    assign busy        = (|pending_q) || (state_q != IDLE);
    // Upper address bits are intentionally dropped so addresses wrap.
    assign unused_addr = ^req_addr;

    rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_arb (
        .req         (pending_q),
        .last_grant  (last_grant_q),
        .grant       (arb_oh),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_q    <= '0;
            pending_q <= '0;
            overrun   <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                op_q[k]    <= OP_RD;
                addr_q[k]  <= '0;
                wdata_q[k] <= '0;
            end
        end else begin
            prev_q    <= req_any;
            pending_q <= (pending_q & ~ack) | set_pend;
            overrun   <= overrun | (rise & pending_q);
            for (int k = 0; k < NUM_CORES; k++) begin
                if (set_pend[k]) begin
                    op_q[k]    <= req_wr[k] ? OP_WR : OP_RD;
                    addr_q[k]  <= req_addr[k*ADDR_W +: MEM_AW];
                    wdata_q[k] <= req_wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_oh_q   <= '0;
            last_grant_q <= IDX_W'(NUM_CORES - 1);
            for (int k = 0; k < NUM_CORES; k++) begin
                rdata_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && arb_valid) begin
                grant_q    <= arb_idx;
                grant_oh_q <= arb_oh;
            end
            if (state_q == RESPOND) begin
                last_grant_q <= grant_q;
                if (op_q[grant_q] == OP_RD) begin
                    rdata_q[grant_q] <= rd_q;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = ACCESS;
            ACCESS:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Array has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS) begin
            if (op_q[grant_q] == OP_WR) begin
                mem[addr_q[grant_q]] <= wdata_q[grant_q];
            end else begin
                rd_q <= mem[addr_q[grant_q]];
            end
        end
    end

    // Read data is forwarded during the ack cycle, then held in rdata_q.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            rdata[k*DATA_W +: DATA_W] = (ack[k] && op_q[k] == OP_RD) ? rd_q : rdata_q[k];
        end
    end

endmodule
